debounce_bank: RTL
==================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 The parameter WIDTH SHALL default to 8 and set the number of independent input channels (1..32).
REQ-002 The parameter DELAY SHALL default to 500000 and set the stable-cycle count before a channel's clean output updates (0..2^24-1).
REQ-003 The parameter SYNC_STAGES SHALL default to 2 and set the synchronizer flop depth per channel (2..4).
REQ-004 The parameters REPEAT_DELAY (default 25000000) and REPEAT_PERIOD (default 5000000) SHALL set the auto-repeat first-repeat and inter-repeat intervals in cycles (both >=1).
REQ-005 The port clock SHALL be an input of width 1 and serve as the single rising-edge clock.
REQ-006 The port reset_n SHALL be an input of width 1 and act as an asynchronous, active-low reset.
REQ-007 The port noisy SHALL be an input of width WIDTH carrying raw asynchronous switch/button levels.
REQ-008 The port clean SHALL be an output of width WIDTH carrying the debounced levels.
REQ-009 The port rise SHALL be an output of width WIDTH carrying one-cycle press pulses per channel.
REQ-010 The port fall SHALL be an output of width WIDTH carrying one-cycle release pulses per channel.
REQ-011 The port changed SHALL be an output of width 1 equal to the OR of all rise and fall bits.

Function
REQ-012 Each channel SHALL pass noisy[i] through a SYNC_STAGES flop chain before any other logic.
REQ-013 Each channel SHALL hold a last-sample register and a counter of width clog2(DELAY+1).
REQ-014 On any cycle where the synchronized value differs from last-sample, last-sample SHALL load it and the counter SHALL clear to 0.
REQ-015 Otherwise, when the counter equals DELAY, clean[i] SHALL load last-sample and the counter SHALL hold (no wrap).
REQ-016 Otherwise the counter SHALL increment by 1.
REQ-017 A noisy step held stable SHALL change clean[i] exactly SYNC_STAGES+DELAY+2 rising edges after the step.
REQ-018 Any bounce before that edge SHALL restart the count, and clean[i] SHALL NOT toggle.
REQ-019 With DELAY=0, clean[i] SHALL follow the synchronized input with two cycles of delay.
REQ-020 rise[i] SHALL be high for exactly the first cycle in which clean[i] is 1 after being 0, and fall[i] SHALL do likewise for the 1-to-0 transition; both outputs are registered.
REQ-021 Channels SHALL be fully independent, and simultaneous events on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-022 Asserting reset_n low SHALL asynchronously clear the sync chains, last-sample, counters, clean, rise, fall, changed and repeat state to 0, at any time, including mid-count.
REQ-023 After reset release, a channel whose input is already high SHALL produce a rise pulse SYNC_STAGES+DELAY+2 cycles later.

Configuration
REQ-024 With DEBOUNCE_BANK_REPEAT_EN defined, each channel SHALL run a repeat FSM with states IDLE, HOLD and REPEAT.
- IDLE->HOLD on the rise pulse.
- HOLD->REPEAT after REPEAT_DELAY cycles of clean[i]=1, emitting an extra rise pulse.
- In REPEAT, an extra rise pulse every REPEAT_PERIOD cycles.
- Any state->IDLE on clean[i]=0, with fall behaving as in REQ-020.
REQ-025 Without DEBOUNCE_BANK_REPEAT_EN, no repeat logic SHALL be generated, the REPEAT_* parameters SHALL be ignored, and rise SHALL pulse only on 0-to-1 transitions.

Structure
REQ-026 A shared package debounce_pkg SHALL hold the repeat-state enumeration (IDLE/HOLD/REPEAT), the counter-width function and the default DELAY constant.
REQ-027 Per-channel logic SHALL live in the sub-module debounce_channel, instantiated WIDTH times by a generate loop; debounce_bank SHALL contain only the instances and the changed reduction.

Verification (WIDTH=4, DELAY=4, SYNC_STAGES=2, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-028 The bench SHALL cover: noisy[0] 0->1 held -> clean[0]=1 and rise[0]=1 at edge 8 only, with changed=1 that cycle.
REQ-029 The bench SHALL cover: noisy[1] toggles 1,0,1 at edges 0,2,4, then held -> clean[1] rises only at edge 12, with no earlier pulse.
REQ-030 The bench SHALL cover: noisy[2]=1 and noisy[3]=1 simultaneously -> rise=4'b1100 in one cycle; a later release of both -> fall=4'b1100 in one cycle.
REQ-031 The bench SHALL cover: reset_n pulsed low at edge 6 of a pending press -> all outputs 0 immediately, and the press is re-detected 8 edges after release.
REQ-032 The bench SHALL cover, with DEBOUNCE_BANK_REPEAT_EN and noisy[0] held high: rise[0] at edges 8, 18, 21, 24 and so on; on release, fall[0] once and no further rise.
REQ-033 The bench SHALL cover, without the macro and the same stimulus as REQ-032: a single rise[0] at edge 8 only.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce bank.
// Contents:
//   DefaultDelay - default stable-cycle count before a clean output updates
//   rep_state_e  - auto-repeat FSM states (IDLE / HOLD / REPEAT)
//   cnt_width()  - width of a counter that must reach 'delay' without wrapping
package debounce_pkg;

  localparam int unsigned DefaultDelay = 500000;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRepeat
  } rep_state_e;

  // clog2(delay+1), clamped to one bit so that delay == 0 still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned delay);
    int unsigned w;
    w = $clog2(delay + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchronizer, stability counter, clean level, registered
// rise/fall pulses and, when DEBOUNCE_BANK_REPEAT_EN is defined, an auto-repeat FSM
// that injects extra rise pulses while the clean level stays high.
// Ports:
//   i_clk    - rising-edge clock
//   i_rst_n  - asynchronous active-low reset
//   i_noisy  - raw asynchronous input level
//   o_clean  - debounced level
//   o_rise   - one-cycle press pulse (plus repeat pulses when enabled)
//   o_fall   - one-cycle release pulse
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DELAY         = DefaultDelay,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_noisy,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CntW = cnt_width(DELAY);
  localparam logic [CntW-1:0] CntMax = CntW'(DELAY);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_last;
  logic [CntW-1:0]        r_cnt;
  logic                   r_clean;
  logic                   r_rise;
  logic                   r_fall;

  logic w_sync;
  logic w_stable;
  logic w_clean_d;
  logic w_rise_edge;
  logic w_fall_edge;
  logic w_rep_pulse;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_noisy};
    end
  end

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_stable = (w_sync == r_last);

  // Clean only updates once the sample has been stable for DELAY counted cycles.
  assign w_clean_d   = (w_stable && (r_cnt == CntMax)) ? r_last : r_clean;
  assign w_rise_edge = w_clean_d & ~r_clean;
  assign w_fall_edge = ~w_clean_d & r_clean;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 1'b0;
      r_cnt  <= '0;
    end else if (!w_stable) begin
      r_last <= w_sync;
      r_cnt  <= '0;
    end else if (r_cnt != CntMax) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Pulses are registered alongside clean so they coincide with its first new cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_clean <= w_clean_d;
      r_rise  <= w_rise_edge | w_rep_pulse;
      r_fall  <= w_fall_edge;
    end
  end

`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam logic [31:0] RepDelayLast  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RepPeriodLast = 32'(REPEAT_PERIOD - 1);

  rep_state_e  r_state;
  rep_state_e  w_state_d;
  logic [31:0] r_rcnt;
  logic [31:0] w_rcnt_d;

  always_comb begin
    w_state_d   = r_state;
    w_rcnt_d    = r_rcnt;
    w_rep_pulse = 1'b0;
    if (!w_clean_d) begin
      w_state_d = StIdle;
      w_rcnt_d  = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_rise_edge) begin
            w_state_d = StHold;
            w_rcnt_d  = '0;
          end
        end
        StHold: begin
          if (r_rcnt == RepDelayLast) begin
            w_rep_pulse = 1'b1;
            w_state_d   = StRepeat;
            w_rcnt_d    = '0;
          end else begin
            w_rcnt_d = r_rcnt + 32'd1;
          end
        end
        StRepeat: begin
          if (r_rcnt == RepPeriodLast) begin
            w_rep_pulse = 1'b1;
            w_rcnt_d    = '0;
          end else begin
            w_rcnt_d = r_rcnt + 32'd1;
          end
        end
        default: begin
          w_state_d = StIdle;
          w_rcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_state_d;
      r_rcnt  <= w_rcnt_d;
    end
  end
`else
  // Repeat parameters have no effect in this build; fold them into a dead signal.
  logic w_unused_repeat;
  assign w_unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign w_rep_pulse     = 1'b0;
`endif

  assign o_clean = r_clean;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/debounce_bank.sv
// Bank of WIDTH independent switch/button debouncers with edge pulses.
// Optional auto-repeat on held channels: define DEBOUNCE_BANK_REPEAT_EN.
// Ports:
//   clock   - rising-edge clock
//   reset_n - asynchronous active-low reset
//   noisy   - raw asynchronous input levels, one bit per channel
//   clean   - debounced levels
//   rise    - one-cycle press pulses per channel
//   fall    - one-cycle release pulses per channel
//   changed - OR of all rise and fall bits
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DELAY         = DefaultDelay,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] noisy,
  output logic [WIDTH-1:0] clean,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .DELAY         (DELAY),
      .SYNC_STAGES   (SYNC_STAGES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_chan (
      .i_clk   (clock),
      .i_rst_n (reset_n),
      .i_noisy (noisy[i]),
      .o_clean (clean[i]),
      .o_rise  (rise[i]),
      .o_fall  (fall[i])
    );
  end

  assign changed = |(rise | fall);

endmodule
